// File: rtl/timer_int_ctrl_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, CTRL bit
// positions and the default interrupt line.
package timer_int_ctrl_pkg;

  typedef enum logic [1:0] {
    TMR_CTRL = 2'd0,
    TMR_CNT  = 2'd1,
    TMR_CMP  = 2'd2,
    TMR_STAT = 2'd3
  } tmr_reg_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE     = 1;
  localparam int CTRL_AR     = 2;
  localparam int CTRL_PSC_LO = 4;
  localparam int CTRL_PSC_HI = 7;
  localparam int STAT_PEND   = 0;
  localparam int TMR_INT_BIT = 0;

  // Only EN, IE, AR and PSC are backed by flops; everything else reads 0.
  localparam logic [7:0] CTRL_MASK = 8'hF7;

  function automatic logic [3:0] ctrl_psc(input logic [7:0] ctrl);
    return ctrl[CTRL_PSC_HI:CTRL_PSC_LO];
  endfunction

endpackage

// File: rtl/timer_int_ctrl_if.sv
// CPU data-bus slice seen by the timer: address, write data, write strobe,
// and the combinational read data / select returned to the CPU read mux.
interface timer_int_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // No handshake: a write completes at the next clk edge whenever
  // sel & mem_ctrl; mem_rd/sel are valid in the same cycle as mem_addr.
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_ctrl;
  logic [DW-1:0] mem_rd;
  logic          sel;

  modport master (output mem_addr, mem_wd, mem_ctrl, input mem_rd, sel);
  modport slave  (input mem_addr, mem_wd, mem_ctrl, output mem_rd, sel);
endinterface

// File: rtl/timer_int_ctrl_prescaler.sv
// Prescaler: psc_cnt counts 0..psc while enabled and emits a one-cycle tick
// when it reaches psc; restart forces the count back to 0.
module timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] psc,
  input  logic       restart,
  output logic       tick
);

  logic [3:0] psc_cnt;
  logic [3:0] psc_cnt_nxt;

  assign tick = en & (psc_cnt == psc);

  // A lowered PSC below the current count lets psc_cnt run on and wrap mod 16.
  always_comb begin
    psc_cnt_nxt = psc_cnt + 4'd1;
    if (!en || restart || tick) psc_cnt_nxt = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psc_cnt <= 4'd0;
    else        psc_cnt <= psc_cnt_nxt;
  end

endmodule

// File: rtl/timer_int_ctrl.sv
// Memory-mapped timer: CTRL/CNT/CMP/STAT registers, prescaled up-counter with
// compare match, sticky pending flag driving one bit of the CPU int vector.
module timer_int_ctrl
  import timer_int_ctrl_pkg::*;
#(
  parameter int            AW      = 16,
  parameter int            DW      = 16,
  parameter int            INT_W   = 8,
  parameter int            INT_BIT = TMR_INT_BIT,
  parameter logic [AW-1:0] BASE    = 16'hF000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  timer_int_ctrl_if.slave       bus,
  output logic [INT_W-1:0]      int_vec
);

  localparam logic [DW-1:0] CNT_ONE = DW'(1);

  logic [7:0]    ctrl;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cmp;
  logic          pend;

  tmr_reg_e idx;
  logic     wr, ctrl_wr, cnt_wr, cmp_wr, stat_wr;
  logic     tick, hit, restart;

  assign idx      = tmr_reg_e'(bus.mem_addr[1:0]);
  assign bus.sel  = (bus.mem_addr[AW-1:2] == BASE[AW-1:2]);
  assign wr       = bus.sel & bus.mem_ctrl;
  assign ctrl_wr  = wr & (idx == TMR_CTRL);
  assign cnt_wr   = wr & (idx == TMR_CNT);
  assign cmp_wr   = wr & (idx == TMR_CMP);
  assign stat_wr  = wr & (idx == TMR_STAT);

  // Any CNT write restarts the prescale period; so does a CTRL write that
  // clears EN, so psc_cnt is 0 on the same edge EN drops.
  assign restart = cnt_wr | (ctrl_wr & ~bus.mem_wd[CTRL_EN]);
  assign hit     = tick & (cnt == cmp);

  timer_prescaler u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ctrl[CTRL_EN]),
    .psc     (ctrl_psc(ctrl)),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= 8'h00;
      cmp  <= '1;
    end else begin
      if (ctrl_wr) ctrl <= bus.mem_wd[7:0] & CTRL_MASK;
      if (cmp_wr)  cmp  <= bus.mem_wd;
    end
  end

  // CPU write to CNT takes priority over a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_wr)  cnt <= bus.mem_wd;
    else if (tick)    cnt <= (hit & ctrl[CTRL_AR]) ? '0 : cnt + CNT_ONE;
  end

  // A match on the same edge as a W1C keeps PEND set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  pend <= 1'b0;
    else if (hit)                                pend <= 1'b1;
    else if (stat_wr && bus.mem_wd[STAT_PEND])   pend <= 1'b0;
  end

  always_comb begin
    bus.mem_rd = '0;
    if (bus.sel) begin
      case (idx)
        TMR_CTRL: bus.mem_rd = {{(DW-8){1'b0}}, ctrl};
        TMR_CNT:  bus.mem_rd = cnt;
        TMR_CMP:  bus.mem_rd = cmp;
        TMR_STAT: bus.mem_rd = {{(DW-1){1'b0}}, pend};
        default:  bus.mem_rd = '0;
      endcase
    end
  end

  always_comb begin
    int_vec          = '0;
    int_vec[INT_BIT] = pend & ctrl[CTRL_IE];
  end

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Bench for timer_int_ctrl: directed scenarios plus random bus traffic, all
// checked every cycle against a register-level reference model.
module tb_timer_int_ctrl;

  localparam int          AW    = 16;
  localparam int          DW    = 16;
  localparam int          INT_W = 8;
  localparam logic [15:0] BASE  = 16'hF000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [INT_W-1:0] int_vec;

  timer_int_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  timer_int_ctrl #(
    .AW(AW), .DW(DW), .INT_W(INT_W), .INT_BIT(0), .BASE(BASE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .int_vec (int_vec)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit          m_en, m_ie, m_ar, m_pend;
  logic [3:0]  m_psc;
  int          m_phase;
  logic [15:0] m_cnt, m_cmp;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_ar = 0; m_pend = 0;
    m_psc = 4'd0; m_phase = 0;
    m_cnt = 16'h0000; m_cmp = 16'hFFFF;
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (a[15:2] != BASE[15:2]) return 16'h0000;
    case (a[1:0])
      2'd0:    return {8'h00, m_psc, 1'b0, m_ar, m_ie, m_en};
      2'd1:    return m_cnt;
      2'd2:    return m_cmp;
      default: return {15'h0, m_pend};
    endcase
  endfunction

  function automatic logic [INT_W-1:0] model_int();
    return {7'h0, m_pend & m_ie};
  endfunction

  // One clock edge of the timer, written from the register-map rules.
  task automatic model_step(input logic [15:0] a, input logic [15:0] d, input logic w);
    bit          tick, hit, hit_wr;
    logic [15:0] n_cnt;
    int          n_phase;
    bit          n_pend;
    tick    = m_en && (m_phase == int'(m_psc));
    hit     = tick && (m_cnt == m_cmp);
    n_cnt   = m_cnt;
    n_pend  = m_pend;
    n_phase = (!m_en || tick) ? 0 : (m_phase + 1) % 16;
    if (tick) n_cnt = (hit && m_ar) ? 16'h0000 : m_cnt + 16'h0001;
    hit_wr = w && (a[15:2] == BASE[15:2]);
    if (hit_wr) begin
      case (a[1:0])
        2'd0: begin
          m_en = d[0]; m_ie = d[1]; m_ar = d[2]; m_psc = d[7:4];
          if (!d[0]) n_phase = 0;
        end
        2'd1: begin n_cnt = d; n_phase = 0; end
        2'd2: m_cmp = d;
        default: if (d[0]) n_pend = 0;
      endcase
    end
    if (hit) n_pend = 1;
    m_cnt = n_cnt; m_phase = n_phase; m_pend = n_pend;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_cycle(input logic [15:0] a, input logic [15:0] d, input logic w);
    @(negedge clk);
    bus.mem_addr = a; bus.mem_wd = d; bus.mem_ctrl = w;
    #1;
    exp_q.push_back(model_rd(a));
    check("sel", {31'h0, bus.sel}, {31'h0, a[15:2] == BASE[15:2]});
    check("int", {24'h0, int_vec}, {24'h0, model_int()});
    check("rd", {16'h0, bus.mem_rd}, {16'h0, exp_q.pop_front()});
    @(posedge clk);
    model_step(a, d, w);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [15:0] d);
    do_cycle(BASE + {14'h0, idx}, d, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(BASE + 16'd1, 16'h0000, 1'b0);
  endtask

  // Cycles until int[0] rises, capped at 64.
  task automatic wait_int(output int n);
    n = 0;
    while (int_vec[0] !== 1'b1 && n < 64) begin
      idle(1);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    int          guard;
    logic [1:0]  idx;
    logic [15:0] a, d;
    logic        w;
    int          r;

    bus.mem_addr = 16'h0000; bus.mem_wd = 16'h0000; bus.mem_ctrl = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Reset values through the bus
    for (int i = 0; i < 4; i++) do_cycle(BASE + 16'(i), 16'h0000, 1'b0);

    // CMP=5, EN|IE|AR, PSC=0: match on the sixth tick, CNT returns to 0
    wr(2'd2, 16'd5);
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h0007);
    wait_int(n);
    check("match_latency_psc0", n, 6);
    idle(3);

    // W1C drops int on the next cycle
    wr(2'd3, 16'h0001);
    check("w1c_clear", {24'h0, int_vec}, 32'h0);
    // W1C on the same edge as a new match: set wins
    guard = 0;
    while (m_cnt != m_cmp && guard < 40) begin idle(1); guard++; end
    check("reach_match", {16'h0, m_cnt}, {16'h0, m_cmp});
    wr(2'd3, 16'h0001);
    check("w1c_vs_set", {31'h0, int_vec[0]}, 32'h1);

    // PSC=3, CMP=2: PEND after 12 cycles
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0002);
    wr(2'd0, 16'h0033);
    wait_int(n);
    check("match_latency_psc3", n, 12);

    // AR=0, CMP=3, CNT=FFFE: wrap through 0 without PEND, match at 3
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);
    wr(2'd2, 16'h0003);
    wr(2'd1, 16'hFFFE);
    wr(2'd0, 16'h0003);
    wait_int(n);
    check("wrap_then_match", n, 6);
    idle(4);

    // CNT write on a tick cycle wins and restarts the prescaler
    wr(2'd3, 16'h0001);
    wr(2'd0, 16'h0031);
    guard = 0;
    while (m_phase != int'(m_psc) && guard < 20) begin idle(1); guard++; end
    wr(2'd1, 16'h0010);
    check("cnt_wr_wins", {16'h0, bus.mem_rd}, 32'h0010);
    idle(3);
    check("psc_restart_hold", {16'h0, bus.mem_rd}, 32'h0010);
    idle(1);
    check("psc_restart_tick", {16'h0, bus.mem_rd}, 32'h0011);

    // Outside the window: no select, no read data, writes ignored
    do_cycle(BASE + 16'd4, 16'h1234, 1'b1);
    check("oob_sel", {31'h0, bus.sel}, 32'h0);
    check("oob_rd", {16'h0, bus.mem_rd}, 32'h0);
    idle(2);

    // Asynchronous reset mid-count with int asserted
    wr(2'd0, 16'h0007);
    wr(2'd2, 16'h0014);
    wr(2'd1, 16'h0012);
    idle(5);
    check("pre_reset_int", {31'h0, int_vec[0]}, 32'h1);
    @(negedge clk);
    bus.mem_ctrl = 1'b0; bus.mem_addr = BASE + 16'd1;
    #2 rst_n = 1'b0;
    #1 check("async_int", {24'h0, int_vec}, 32'h0);
    check("async_cnt", {16'h0, bus.mem_rd}, 32'h0);
    bus.mem_addr = BASE + 16'd2;
    #0.5 check("async_cmp", {16'h0, bus.mem_rd}, 32'hFFFF);
    bus.mem_addr = BASE;
    #0.5 check("async_ctrl", {16'h0, bus.mem_rd}, 32'h0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // Random bus traffic against the model
    for (int k = 0; k < 400; k++) begin
      r   = $urandom_range(0, 9);
      idx = 2'($urandom_range(0, 3));
      w   = (r < 4);
      case (idx)
        2'd0:    d = (16'($urandom) & 16'h0037) | ((r == 1) ? 16'h0000 : 16'h0001);
        2'd1:    d = 16'($urandom_range(0, 24));
        2'd2:    d = 16'($urandom_range(0, 24));
        default: d = 16'($urandom_range(0, 1));
      endcase
      a = (r == 9) ? 16'($urandom_range(0, 16'hFFFF)) : BASE + {14'h0, idx};
      do_cycle(a, d, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
